// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the buffer write arbiter
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  // Constant-evaluable ceil(log2(n)); callers only use n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Wraps at n, not at the next power of two.
  function automatic int ptr_inc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick
  import arb_pkg::*;
#(
  parameter int Requesters = 4,
  localparam int IdxWidth  = clog2(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IdxWidth-1:0]   ptr,
  output logic [Requesters-1:0] grant,
  output logic [IdxWidth-1:0]   idx,
  output logic                  any_valid
);

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < Requesters; i++) begin
      k = int'(ptr) + i;
      if (k >= Requesters) k = k - Requesters;
      if (!any_valid && req[k]) begin
        any_valid = 1'b1;
        grant[k]  = 1'b1;
        idx       = IdxWidth'(k);
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// rtl/buffer_write_arbiter.sv - round-robin write arbiter with burst lock for a shared holding register
module buffer_write_arbiter
  import arb_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Requesters = 4,
  localparam int IdxWidth  = clog2(Requesters)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Requesters-1:0]       req,
  input  logic [Requesters-1:0]       lock,
  input  logic [Requesters*Width-1:0] data,
  output logic [Requesters-1:0]       ack,
  output logic                        buf_ce,
  output logic [Width-1:0]            buf_d,
  output logic [IdxWidth-1:0]         owner_idx,
  output logic                        busy
);

  logic                  state, state_nxt;
  logic [IdxWidth-1:0]   ptr, ptr_nxt;
  logic [Requesters-1:0] pick_grant;
  logic [IdxWidth-1:0]   pick_idx;
  logic                  pick_any;
  logic [Requesters-1:0] ack_c;
  logic                  accept;
  logic [IdxWidth-1:0]   win_idx;

  rr_pick #(.Requesters(Requesters)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Pointer advances past the winner only once the register is released.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          if (lock[pick_idx]) state_nxt = ST_OWNED;
          else ptr_nxt = IdxWidth'(ptr_inc(int'(pick_idx), Requesters));
        end
      end
      default: begin
        if (!lock[owner_idx]) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = IdxWidth'(ptr_inc(int'(owner_idx), Requesters));
        end
      end
    endcase
  end

  // While owned, owner_idx names the holder since only it can be accepted.
  always_comb begin
    ack_c   = '0;
    accept  = 1'b0;
    win_idx = pick_idx;
    if (state == ST_OWNED) begin
      win_idx           = owner_idx;
      accept            = req[owner_idx];
      ack_c[owner_idx]  = req[owner_idx];
    end else begin
      accept = pick_any;
      ack_c  = pick_grant;
    end
  end

  assign ack  = rst ? '0 : ack_c;
  assign busy = (state == ST_OWNED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_ce    <= 1'b0;
      buf_d     <= '0;
      owner_idx <= '0;
    end else begin
      buf_ce <= accept;
      if (accept) begin
        buf_d     <= data[win_idx*Width +: Width];
        owner_idx <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// tb/tb_buffer_write_arbiter.sv - directed self-checking bench for buffer_write_arbiter
module tb_buffer_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        buf_ce;
  logic [7:0]  buf_d;
  logic [1:0]  owner_idx;
  logic        busy;
  logic [7:0]  q;

  logic        rst3;
  logic [2:0]  req3, lock3;
  logic [23:0] data3;
  logic [2:0]  ack3;
  logic        buf_ce3;
  logic [7:0]  buf_d3;
  logic [1:0]  owner_idx3;
  logic        busy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buffer_write_arbiter #(.Width(8), .Requesters(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
    .ack(ack), .buf_ce(buf_ce), .buf_d(buf_d), .owner_idx(owner_idx), .busy(busy)
  );

  buffer_write_arbiter #(.Width(8), .Requesters(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .lock(lock3), .data(data3),
    .ack(ack3), .buf_ce(buf_ce3), .buf_d(buf_d3), .owner_idx(owner_idx3), .busy(busy3)
  );

  // Shared holding register fed by the arbiter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (buf_ce) q <= buf_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    check("ack3_onehot", 32'($countones(ack3) <= 1), 32'd1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fair_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] fair_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] dat      [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
  logic [2:0] alt_ack  [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
  logic [1:0] alt_idx  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
  logic [7:0] alt_d    [4] = '{8'h11, 8'h33, 8'h11, 8'h33};

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    rst3  = 1'b1;
    req3  = 3'b000;
    lock3 = 3'b000;
    data3 = {8'h33, 8'h22, 8'h11};

    // Reset held three cycles with every request raised
    tick; tick; tick;
    check("rst_ack", ack, 4'b0000);
    check("rst_ce", buf_ce, 1'b0);
    check("rst_d", buf_d, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner_idx, 2'd0);

    rst = 1'b0;
    #1;
    // Fairness rotation, buf_d lags the grant by one cycle
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fair_ack%0d", k), ack, fair_ack[k]);
      tick;
      check($sformatf("fair_ce%0d", k), buf_ce, 1'b1);
      check($sformatf("fair_d%0d", k), buf_d, dat[fair_idx[k]]);
      check($sformatf("fair_own%0d", k), owner_idx, fair_idx[k]);
    end
    check("fair_q", q, 8'h44);

    req = 4'b0000;
    #1;
    check("idle_ack", ack, 4'b0000);
    tick;
    check("idle_ce", buf_ce, 1'b0);
    check("idle_hold_d", buf_d, 8'h11);

    // Single writer, ptr now 1
    req = 4'b0100;
    #1;
    check("single_ack", ack, 4'b0100);
    tick;
    req = 4'b0000;
    check("single_ce", buf_ce, 1'b1);
    check("single_d", buf_d, 8'hA5);
    check("single_own", owner_idx, 2'd2);
    tick;
    check("single_q", q, 8'hA5);
    check("single_ce_off", buf_ce, 1'b0);

    // ptr=3: requester 0 wins and moves ptr to 1
    req = 4'b0001;
    #1;
    check("prep_ack", ack, 4'b0001);
    tick;

    // Burst by requester 1 with one owner-idle cycle inside
    req  = 4'b1111;
    lock = 4'b0010;
    #1;
    check("burst_ack_a", ack, 4'b0010);
    tick;
    check("burst_busy_a", busy, 1'b1);
    check("burst_d_a", buf_d, 8'h22);
    #1;
    check("burst_ack_b", ack, 4'b0010);
    tick;
    check("burst_busy_b", busy, 1'b1);
    req = 4'b1101;
    #1;
    check("burst_gap_ack", ack, 4'b0000);
    tick;
    check("burst_gap_ce", buf_ce, 1'b0);
    check("burst_gap_busy", busy, 1'b1);
    req = 4'b1111;
    #1;
    check("burst_ack_c", ack, 4'b0010);
    tick;
    check("burst_ce_c", buf_ce, 1'b1);
    lock = 4'b0000;
    #1;
    check("burst_exit_ack", ack, 4'b0010);
    tick;
    check("burst_exit_busy", busy, 1'b0);
    check("burst_exit_ce", buf_ce, 1'b1);
    #1;
    check("burst_next_ack", ack, 4'b0100);
    tick;
    check("burst_next_own", owner_idx, 2'd2);

    // Lock alone in IDLE earns nothing
    req  = 4'b0000;
    lock = 4'b0100;
    #1;
    check("lockonly_ack", ack, 4'b0000);
    tick;
    check("lockonly_busy", busy, 1'b0);
    check("lockonly_ce", buf_ce, 1'b0);

    // Requester 3 takes ownership, then reset mid-burst
    req  = 4'b1000;
    lock = 4'b1000;
    #1;
    check("own3_ack", ack, 4'b1000);
    tick;
    check("own3_busy", busy, 1'b1);
    check("own3_own", owner_idx, 2'd3);
    check("own3_d", buf_d, 8'h44);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ce", buf_ce, 1'b0);
    check("midrst_ack", ack, 4'b0000);
    tick;
    rst  = 1'b0;
    req  = 4'b1001;
    lock = 4'b0000;
    #1;
    check("postrst_ack", ack, 4'b0001);
    tick;
    check("postrst_own", owner_idx, 2'd0);
    req = 4'b0000;

    // Three requesters: pointer must wrap at 3
    rst3 = 1'b0;
    req3 = 3'b101;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_ack%0d", k), ack3, alt_ack[k]);
      tick;
      check($sformatf("wrap_own%0d", k), owner_idx3, alt_idx[k]);
      check($sformatf("wrap_d%0d", k), buf_d3, alt_d[k]);
    end
    req3 = 3'b000;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
